lane_capture_arb: RTL and testbench
===================================

LANE_CAPTURE_ARB -- requirements
Module: lane_capture_arb

Interface
REQ-001 Parameter NREQ, default 4, sets the number of requesters sharing the capture register bank.
REQ-002 Parameter LANES, default 4, sets the number of 1-bit capture lanes in the shared bank.
REQ-003 Parameter MAXBURST, default 4, sets the maximum consecutive grants a locking requester may hold; legal range 1..16.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester transfer request.
REQ-007 lock  input  NREQ  per-requester burst hold request; qualified by the matching req bit.
REQ-008 wdata  input  NREQ*LANES  per-requester lane data; requester i occupies bits [i*LANES +: LANES].
REQ-009 wmask  input  NREQ*LANES  per-requester lane write mask, same packing as wdata.
REQ-010 gnt  output  NREQ  registered one-hot grant; all zero when idle.
REQ-011 result  output  LANES  shared capture register bank contents.
REQ-012 busy  output  1  high while the FSM is in GRANT.
REQ-013 sig  output  64  running capture signature; see Configuration.

Function
REQ-014 The FSM SHALL have two states, IDLE and GRANT, with a winner index w, a round-robin pointer ptr and a burst counter bcnt.
REQ-015 In IDLE with any req bit high, the block SHALL select the first requester with req high, searching from ptr upward with wrap, and enter GRANT with gnt one-hot at w on the next cycle.
REQ-016 In GRANT, if req[w] is high, the clock edge SHALL apply result <= (result & ~wmask_w) | (wdata_w & wmask_w); if req[w] is low, result SHALL hold.
REQ-017 Latency: req rising in cycle N from IDLE SHALL give gnt in cycle N+1 and the updated result visible in cycle N+2.
REQ-018 In GRANT, if lock[w] and req[w] are high and bcnt < MAXBURST-1, the block SHALL stay in GRANT on w and increment bcnt.
REQ-019 Otherwise, ptr SHALL become (w+1) mod NREQ and bcnt SHALL clear. If any req is high, the block SHALL re-arbitrate from the new ptr and stay in GRANT with no idle bubble. If no req is high, it SHALL return to IDLE.
REQ-020 During re-arbitration, req[w] SHALL be included but SHALL have the lowest priority.
REQ-021 Requesters SHALL hold req, wdata and wmask stable until their gnt cycle; a req dropped before its grant cycle SHALL cause no write.
REQ-022 gnt SHALL never have more than one bit set; busy SHALL equal (state == GRANT).
REQ-023 An all-zero wmask SHALL consume a grant cycle without changing result.

Reset
REQ-024 While rst_n is low, the block SHALL immediately, independent of clk, force: state=IDLE, gnt=0, busy=0, result=0, ptr=0, bcnt=0, sig=0.
REQ-025 If reset asserts mid-GRANT, the in-flight write SHALL be discarded; the first grant after release SHALL follow REQ-015 with ptr=0.

Configuration
REQ-026 Macro LANE_CAPTURE_SIG_EN defined: on every write edge per REQ-016, the block SHALL apply sig <= {sig[62:0], sig[63]^sig[2]^sig[0]} ^ {zero-extended new result}.
REQ-027 Macro LANE_CAPTURE_SIG_EN undefined: no signature logic SHALL exist, and sig SHALL be constant 0.

Verification
REQ-028 Reset: rst_n=0 with req=4'hF -> gnt=0, busy=0, result=4'h0, sig=0.
REQ-029 Single request: req=4'b0001, wdata0=4'hA, wmask0=4'hF in cycle N -> gnt=4'b0001 in N+1; result=4'hA in N+2; busy=0 in N+2 if req dropped in N+1.
REQ-030 Round robin: req=4'hF held, lock=0, from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no bubble.
REQ-031 Burst limit: req0 and req1 high, lock0 high, MAXBURST=4 -> gnt=0001 for exactly 4 cycles, then gnt=0010.
REQ-032 Masked write: result=4'hF; req2 with wdata2=4'h0, wmask2=4'b0101 -> result=4'hA.
REQ-033 Signature (macro defined): from sig=0, a single capture giving result=4'hA -> sig=64'h000000000000000A. With the macro undefined, sig stays 0.

Source files
------------

// File: rtl/lane_capture_arb.sv
// lane_capture_arb: round-robin arbiter that lets NREQ requesters take turns
// writing a shared LANES-bit capture register bank under a per-lane mask.
// A requester holding lock keeps the grant for up to MAXBURST cycles.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   req     per-requester transfer request            [NREQ]
//   lock    per-requester burst hold (qualified by req) [NREQ]
//   wdata   per-requester lane data, slot i at [i*LANES +: LANES]
//   wmask   per-requester lane mask, same packing as wdata
//   gnt     registered one-hot grant, zero when idle   [NREQ]
//   result  shared capture register bank               [LANES]
//   busy    high while a grant is active
//   sig     running capture signature                  [64]
//
// Build option: define LANE_CAPTURE_SIG_EN to enable the capture signature;
// without it sig is tied to zero and no signature logic exists.
module lane_capture_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LANES    = 4,
  parameter int unsigned MAXBURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*LANES-1:0]   wdata,
  input  logic [NREQ*LANES-1:0]   wmask,
  output logic [NREQ-1:0]         gnt,
  output logic [LANES-1:0]        result,
  output logic                    busy,
  output logic [63:0]             sig
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state_q, state_n;
  logic [IW-1:0]    w_q, w_n;
  logic [IW-1:0]    ptr_q, ptr_n;
  logic [BW-1:0]    bcnt_q, bcnt_n;
  logic [NREQ-1:0]  gnt_n;
  logic             busy_n;
  logic [LANES-1:0] result_n;

  // Current winner's request, lock, data and mask
  logic             req_w, lock_w;
  logic [LANES-1:0] wd_w, wm_w;

  always_comb begin
    req_w  = 1'b0;
    lock_w = 1'b0;
    wd_w   = '0;
    wm_w   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_q == IW'(i)) begin
        req_w  = req[i];
        lock_w = lock[i];
        wd_w   = wdata[i*LANES +: LANES];
        wm_w   = wmask[i*LANES +: LANES];
      end
    end
  end

  // Successor of the winner, modulo NREQ
  logic [IW-1:0] w_inc;
  assign w_inc = (w_q == IW'(NREQ - 1)) ? '0 : w_q + IW'(1);

  // Round-robin search: rotate req so the start index sits at bit 0, then
  // take the lowest set bit. Starting at w+1 leaves w as the last candidate.
  logic [IW-1:0]   arb_start;
  logic [NREQ-1:0] rot;
  logic [IW-1:0]   arb_idx;
  logic            arb_hit;

  assign arb_start = (state_q == GRANT) ? w_inc : ptr_q;
  assign rot       = NREQ'({req, req} >> arb_start);

  always_comb begin
    arb_idx = '0;
    arb_hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!arb_hit && rot[k]) begin
        arb_hit = 1'b1;
        arb_idx = IW'((int'(arb_start) + k) % NREQ);
      end
    end
  end

  logic [LANES-1:0] wr_val;
  assign wr_val = (result & ~wm_w) | (wd_w & wm_w);

`ifdef LANE_CAPTURE_SIG_EN
  logic [63:0] sig_n;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_n  = state_q;
    w_n      = w_q;
    ptr_n    = ptr_q;
    bcnt_n   = bcnt_q;
    gnt_n    = gnt;
    busy_n   = busy;
    result_n = result;
`ifdef LANE_CAPTURE_SIG_EN
    sig_n    = sig;
`endif
    case (state_q)
      IDLE: begin
        if (arb_hit) begin
          state_n = GRANT;
          w_n     = arb_idx;
          gnt_n   = NREQ'(1) << arb_idx;
          busy_n  = 1'b1;
        end
      end
      GRANT: begin
        if (req_w) begin
          result_n = wr_val;
`ifdef LANE_CAPTURE_SIG_EN
          sig_n = {sig[62:0], sig[63] ^ sig[2] ^ sig[0]} ^ 64'(wr_val);
`endif
        end
        if (lock_w && req_w && (bcnt_q < BW'(MAXBURST - 1))) begin
          bcnt_n = bcnt_q + BW'(1);
        end else begin
          ptr_n  = w_inc;
          bcnt_n = '0;
          if (arb_hit) begin
            w_n   = arb_idx;
            gnt_n = NREQ'(1) << arb_idx;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
        bcnt_n  = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      result  <= '0;
`ifdef LANE_CAPTURE_SIG_EN
      sig     <= '0;
`endif
    end else begin
      state_q <= state_n;
      w_q     <= w_n;
      ptr_q   <= ptr_n;
      bcnt_q  <= bcnt_n;
      gnt     <= gnt_n;
      busy    <= busy_n;
      result  <= result_n;
`ifdef LANE_CAPTURE_SIG_EN
      sig     <= sig_n;
`endif
    end
  end

`ifndef LANE_CAPTURE_SIG_EN
  assign sig = '0;
`endif

endmodule

// File: tb/tb_lane_capture_arb.sv
// Testbench for lane_capture_arb: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the rules.
module tb_lane_capture_arb;

  localparam int NREQ     = 4;
  localparam int LANES    = 4;
  localparam int MAXBURST = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*LANES-1:0] wdata;
  logic [NREQ*LANES-1:0] wmask;
  logic [NREQ-1:0]       gnt;
  logic [LANES-1:0]      result;
  logic                  busy;
  logic [63:0]           sig;

  lane_capture_arb #(.NREQ(NREQ), .LANES(LANES), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wdata(wdata),
    .wmask(wmask), .gnt(gnt), .result(result), .busy(busy), .sig(sig)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model
  bit         m_active;
  int         m_owner;
  int         m_next;
  int         m_held;
  logic [3:0] m_res;
  logic [63:0] m_sig;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (req[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_active = 1'b0;
    m_owner  = 0;
    m_next   = 0;
    m_held   = 0;
    m_res    = '0;
    m_sig    = '0;
  endtask

  task automatic model_edge();
    logic [3:0] d, m;
    if (!m_active) begin
      if (req != '0) begin
        m_owner  = first_from(m_next);
        m_active = 1'b1;
      end
    end else begin
      d = wdata[m_owner*LANES +: LANES];
      m = wmask[m_owner*LANES +: LANES];
      if (req[m_owner]) begin
        m_res = (m_res & ~m) | (d & m);
`ifdef LANE_CAPTURE_SIG_EN
        m_sig = {m_sig[62:0], m_sig[63] ^ m_sig[2] ^ m_sig[0]} ^ 64'(m_res);
`endif
      end
      if (lock[m_owner] && req[m_owner] && m_held < MAXBURST - 1) begin
        m_held++;
      end else begin
        m_next = (m_owner + 1) % NREQ;
        m_held = 0;
        if (req != '0) m_owner = first_from(m_next);
        else m_active = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] eg;
    eg = m_active ? 4'(1 << m_owner) : 4'h0;
    check($sformatf("%s.gnt", tag), 64'(gnt), 64'(eg));
    check($sformatf("%s.busy", tag), 64'(busy), 64'(m_active));
    check($sformatf("%s.result", tag), 64'(result), 64'(m_res));
    check($sformatf("%s.sig", tag), sig, m_sig);
    check($sformatf("%s.onehot", tag), 64'($countones(gnt) <= 1), 64'(1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare_all($sformatf("cyc%0d", cyc));
  endtask

  // Assert reset between edges so the asynchronous clear is observable
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = 4'hF;
    #1;
    model_clear();
    compare_all("rst_async");
    @(posedge clk);
    @(negedge clk);
    compare_all("rst_hold");
    req   = '0;
    lock  = '0;
    rst_n = 1'b1;
  endtask

  logic [3:0] rr_seq [5];

  initial begin
    rst_n = 1'b1;
    req   = '0;
    lock  = '0;
    wdata = '0;
    wmask = '0;
    model_clear();
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with all requests high
    apply_reset();
    check("reset_gnt", 64'(gnt), 64'h0);
    check("reset_result", 64'(result), 64'h0);

    // Single request: grant next cycle, result the cycle after
    req = 4'b0001; wdata[3:0] = 4'hA; wmask[3:0] = 4'hF;
    tick();
    check("single_gnt", 64'(gnt), 64'h1);
    tick();
    check("single_result", 64'(result), 64'hA);
`ifdef LANE_CAPTURE_SIG_EN
    check("single_sig", sig, 64'h000000000000000A);
`else
    check("single_sig", sig, 64'h0);
`endif
    req = '0;
    tick();
    check("single_idle", 64'(busy), 64'h0);

    // Round robin with all requesters and no lock
    apply_reset();
    req = 4'hF; lock = '0; wmask = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rr_%0d", i), 64'(gnt), 64'(rr_seq[i]));
    end

    // Burst limit for a locking requester
    apply_reset();
    req = 4'b0011; lock = 4'b0001;
    for (int i = 0; i < MAXBURST; i++) begin
      tick();
      check($sformatf("burst_%0d", i), 64'(gnt), 64'h1);
    end
    tick();
    check("burst_end", 64'(gnt), 64'h2);

    // Masked write onto an all-ones bank
    apply_reset();
    req = 4'b0001; wdata = 16'h000F; wmask = 16'h000F;
    tick();
    req = 4'b0101; wdata[11:8] = 4'h0; wmask[11:8] = 4'b0101;
    tick();
    check("mask_pre", 64'(result), 64'hF);
    check("mask_gnt2", 64'(gnt), 64'h4);
    req = 4'b0100;
    tick();
    check("mask_result", 64'(result), 64'hA);
    req = '0;
    tick();

    // All-zero mask consumes a grant without writing
    req = 4'b0010; wdata[7:4] = 4'hF; wmask[7:4] = 4'h0;
    tick();
    tick();
    check("zeromask_result", 64'(result), 64'hA);
    req = '0;
    tick();

    // Reset mid-grant discards the write; next grant starts from index 0
    req = 4'hF; wdata = 16'hFFFF; wmask = 16'hFFFF;
    tick();
    apply_reset();
    check("midrst_result", 64'(result), 64'h0);
    req = 4'hF;
    tick();
    check("midrst_gnt", 64'(gnt), 64'h1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) apply_reset();
      req   = 4'($urandom());
      lock  = 4'($urandom());
      wdata = 16'($urandom());
      wmask = 16'($urandom());
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
